// File: rtl/rv32i_fetch_unit_pkg.sv
// Shared constants and enums for the rv32i fetch stage.
// Sizes the instruction memory and encodes the FSM and next-pc actions.
package rv32i_fetch_unit_pkg;

    localparam int unsigned INSTR_MEM_DEPTH = 32;
    localparam int unsigned INSTR_MEM_WIDTH = 32;

    localparam logic [29:0] INSTR_MEM_WORDS  = 30'(INSTR_MEM_DEPTH);
    localparam logic [31:0] RV32I_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_e;

    typedef enum logic [2:0] {
        ACT_ACCEPT   = 3'd0,
        ACT_REDIRECT = 3'd1,
        ACT_MISALIGN = 3'd2,
        ACT_HOLD     = 3'd3,
        ACT_RANGE    = 3'd4
    } fetch_act_e;

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Instruction-memory bus and IF/ID bundle of the fetch stage.
// master = fetch unit, slave = memory plus decode side.
interface rv32i_fetch_unit_if;
    import rv32i_fetch_unit_pkg::*;

    logic [31:0]                  imem_addr;
    logic [INSTR_MEM_WIDTH-1:0]   imem_instr;
    logic                         id_valid;
    logic [31:0]                  id_instr;
    logic [31:0]                  id_pc;
    logic [31:0]                  id_pc_plus4;

    modport master (
        output imem_addr,
        input  imem_instr,
        output id_valid,
        output id_instr,
        output id_pc,
        output id_pc_plus4
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4
    );

endinterface

// File: rtl/rv32i_next_pc.sv
// Combinational next-pc decision for the fetch stage.
// Classifies the cycle into one mutually exclusive action.
module rv32i_next_pc
    import rv32i_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output fetch_act_e  act,
    output logic [31:0] pc_next,
    output logic [31:0] fault_addr
);

    logic misalign;
    logic redir;
    logic hold;
    logic range_err;

    // Priority is folded into the terms so the decoder stays unique.
    assign misalign  = redirect_valid & (|redirect_target[1:0]);
    assign redir     = redirect_valid & ~(|redirect_target[1:0]);
    assign hold      = ~redirect_valid & stall;
    assign range_err = ~redirect_valid & ~stall
                     & (pc[31:2] >= INSTR_MEM_WORDS);

    always_comb begin
        act        = ACT_ACCEPT;
        pc_next    = pc + 32'd4;
        fault_addr = pc;
        unique case (1'b1)
            misalign: begin
                act        = ACT_MISALIGN;
                pc_next    = pc;
                fault_addr = redirect_target;
            end
            redir: begin
                act     = ACT_REDIRECT;
                pc_next = redirect_target;
            end
            hold: begin
                act     = ACT_HOLD;
                pc_next = pc;
            end
            range_err: begin
                act     = ACT_RANGE;
                pc_next = pc;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rv32i instruction-fetch stage: PC, IF/ID register and sticky fault FSM.
// Registers live here; the action decode sits in rv32i_next_pc.
module rv32i_fetch_unit
    import rv32i_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rv32i_fetch_unit_if.master    bus,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_target,
    output logic                  fault,
    output logic [31:0]           fault_addr,
    output logic [31:0]           fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  pc4_q, pc4_d;
    logic [31:0]  faddr_q, faddr_d;
    logic [31:0]  count_q, count_d;

    fetch_act_e   act;
    logic [31:0]  np_pc;
    logic [31:0]  np_faddr;

    rv32i_next_pc u_next_pc (
        .pc              (pc_q),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .act             (act),
        .pc_next         (np_pc),
        .fault_addr      (np_faddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= RV32I_NOP;
            id_pc_q <= '0;
            pc4_q   <= '0;
            faddr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            id_pc_q <= id_pc_d;
            pc4_q   <= pc4_d;
            faddr_q <= faddr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        id_pc_d = id_pc_q;
        pc4_d   = pc4_q;
        faddr_d = faddr_q;
        count_d = count_q;
        // FAULT keeps every register frozen until reset.
        if (state_q == FETCH_RUN) begin
            unique case (act)
                ACT_MISALIGN: begin
                    state_d = FETCH_FAULT;
                    faddr_d = np_faddr;
                    valid_d = 1'b0;
                    instr_d = RV32I_NOP;
                end
                ACT_REDIRECT: begin
                    pc_d    = np_pc;
                    valid_d = 1'b0;
                    instr_d = RV32I_NOP;
                end
                ACT_HOLD: ;
                ACT_RANGE: begin
                    state_d = FETCH_FAULT;
                    faddr_d = np_faddr;
                    valid_d = 1'b0;
                end
                ACT_ACCEPT: begin
                    instr_d = bus.imem_instr;
                    id_pc_d = pc_q;
                    pc4_d   = pc_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = np_pc;
                    count_d = count_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.id_valid    = valid_q;
    assign bus.id_instr    = instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = pc4_q;
    assign fault           = (state_q == FETCH_FAULT);
    assign fault_addr      = faddr_q;
    assign fetch_count     = count_q;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit: vector table plus
// hand sequences for async reset and the memory-range fault.
module tb_rv32i_fetch_unit;
    import rv32i_fetch_unit_pkg::*;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        fault;
        logic [31:0] faddr;
        logic [31:0] cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    logic [31:0] mem [INSTR_MEM_DEPTH];
    int          total;
    int          bad;
    vec_t        vt [15];

    rv32i_fetch_unit_if bus ();

    rv32i_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fault           (fault),
        .fault_addr      (fault_addr),
        .fetch_count     (fetch_count)
    );

    assign bus.imem_instr = (bus.imem_addr[31:2] < INSTR_MEM_WORDS)
                          ? mem[bus.imem_addr[6:2]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic rv,
                        input logic [31:0] t);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " addr"},  bus.imem_addr, 32'h0);
        chk({tag, " valid"}, 32'(bus.id_valid), 32'h0);
        chk({tag, " instr"}, bus.id_instr, 32'h0000_0013);
        chk({tag, " pc"},    bus.id_pc, 32'h0);
        chk({tag, " pc4"},   bus.id_pc_plus4, 32'h0);
        chk({tag, " fault"}, 32'(fault), 32'h0);
        chk({tag, " faddr"}, fault_addr, 32'h0);
        chk({tag, " cnt"},   fetch_count, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < INSTR_MEM_DEPTH; i++)
            mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_0013;

        // stall rv  tgt  | addr valid instr pc pc4 fault faddr cnt
        vt[0]  = '{0, 0, 0, 32'h04, 1, 32'h0050_0093, 32'h00, 32'h04, 0, 0, 1};
        vt[1]  = '{0, 0, 0, 32'h08, 1, 32'h0010_0113, 32'h04, 32'h08, 0, 0, 2};
        vt[2]  = '{1, 0, 0, 32'h08, 1, 32'h0010_0113, 32'h04, 32'h08, 0, 0, 2};
        vt[3]  = '{1, 0, 0, 32'h08, 1, 32'h0010_0113, 32'h04, 32'h08, 0, 0, 2};
        vt[4]  = '{0, 0, 0, 32'h0C, 1, 32'h0020_81B3, 32'h08, 32'h0C, 0, 0, 3};
        vt[5]  = '{0, 1, 32'h40, 32'h40, 0, 32'h13, 32'h08, 32'h0C, 0, 0, 3};
        vt[6]  = '{0, 0, 0, 32'h44, 1, 32'hC0DE_0010, 32'h40, 32'h44, 0, 0, 4};
        vt[7]  = '{1, 1, 32'h20, 32'h20, 0, 32'h13, 32'h40, 32'h44, 0, 0, 4};
        vt[8]  = '{0, 1, 32'h10, 32'h10, 0, 32'h13, 32'h40, 32'h44, 0, 0, 4};
        vt[9]  = '{0, 1, 32'h18, 32'h18, 0, 32'h13, 32'h40, 32'h44, 0, 0, 4};
        vt[10] = '{0, 0, 0, 32'h1C, 1, 32'hC0DE_0006, 32'h18, 32'h1C, 0, 0, 5};
        vt[11] = '{0, 1, 32'h42, 32'h1C, 0, 32'h13, 32'h18, 32'h1C, 1, 32'h42, 5};
        vt[12] = '{0, 1, 32'h00, 32'h1C, 0, 32'h13, 32'h18, 32'h1C, 1, 32'h42, 5};
        vt[13] = '{1, 0, 0, 32'h1C, 0, 32'h13, 32'h18, 32'h1C, 1, 32'h42, 5};
        vt[14] = '{0, 0, 0, 32'h1C, 0, 32'h13, 32'h18, 32'h1C, 1, 32'h42, 5};

        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        rst_n           = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        chk_reset("rst");

        for (int i = 0; i < 15; i++) begin
            step(vt[i].stall, vt[i].rv, vt[i].tgt);
            chk($sformatf("v%0d addr", i), bus.imem_addr, vt[i].addr);
            chk($sformatf("v%0d valid", i), 32'(bus.id_valid),
                32'(vt[i].valid));
            chk($sformatf("v%0d instr", i), bus.id_instr, vt[i].instr);
            chk($sformatf("v%0d pc", i), bus.id_pc, vt[i].pc);
            chk($sformatf("v%0d pc4", i), bus.id_pc_plus4, vt[i].pc4);
            chk($sformatf("v%0d fault", i), 32'(fault), 32'(vt[i].fault));
            chk($sformatf("v%0d faddr", i), fault_addr, vt[i].faddr);
            chk($sformatf("v%0d cnt", i), fetch_count, vt[i].cnt);
        end

        // Async reset while clk is high: no edge may be needed.
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset("rel");

        // Run sequentially off the end of instruction memory.
        for (int i = 0; i < INSTR_MEM_DEPTH; i++)
            step(1'b0, 1'b0, 32'h0);
        chk("end addr", bus.imem_addr, 32'd128);
        chk("end cnt", fetch_count, 32'd32);
        chk("end fault", 32'(fault), 32'h0);
        chk("end pc", bus.id_pc, 32'd124);
        chk("end instr", bus.id_instr, 32'hC0DE_001F);
        step(1'b0, 1'b0, 32'h0);
        chk("oor fault", 32'(fault), 32'h1);
        chk("oor faddr", fault_addr, 32'd128);
        chk("oor cnt", fetch_count, 32'd32);
        chk("oor valid", 32'(bus.id_valid), 32'h0);
        step(1'b0, 1'b1, 32'h8);
        chk("oor hold addr", bus.imem_addr, 32'd128);
        chk("oor hold fault", 32'(fault), 32'h1);

        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("clr");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        chk("post addr", bus.imem_addr, 32'h4);
        chk("post instr", bus.id_instr, 32'h0050_0093);
        chk("post cnt", fetch_count, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
